input_route_ctrl: RTL and testbench

- Wormhole successor of the router input controller. It pops flits from the input-port FIFO, decodes the flit type, and computes the XY route on head flits. The route is locked for the whole packet until the tail leaves.
- One-flit output register with a valid/grant handshake toward the switch allocator and crossbar. Throughput: 1 flit/cycle.
- Adds protocol-error detection with a saturating error counter.
- Sits between the input FIFO and the switch allocator, one instance per router input port.

---
 rtl/router_pkg.sv | 35 +++
 rtl/xy_route_calc.sv | 28 ++
 rtl/input_route_ctrl.sv | 150 +++++++++++++++
 tb/tb_input_route_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: flit-type codes, output-port codes and the
// input-controller state type. Reused by the allocator and crossbar.
package router_pkg;

   // Flit type lives in the two MSBs of every flit.
   localparam logic [1:0] FLIT_BODY   = 2'b00;
   localparam logic [1:0] FLIT_HEAD   = 2'b01;
   localparam logic [1:0] FLIT_TAIL   = 2'b10;
   localparam logic [1:0] FLIT_SINGLE = 2'b11;

   // Output-port codes driven toward the switch allocator.
   localparam logic [2:0] PORT_LOCAL = 3'b000;
   localparam logic [2:0] PORT_E     = 3'b001;
   localparam logic [2:0] PORT_W     = 3'b010;
   localparam logic [2:0] PORT_N     = 3'b011;
   localparam logic [2:0] PORT_S     = 3'b100;
   localparam logic [2:0] PORT_NONE  = 3'b111;

   typedef enum logic [0:0] {
      StIdle,
      StPkt
   } route_state_e;

   // Head and single flits carry a destination address.
   function automatic logic carries_addr(input logic [1:0] ftype);
      logic res;
      case (ftype)
         FLIT_HEAD, FLIT_SINGLE: res = 1'b1;
         FLIT_BODY, FLIT_TAIL:   res = 1'b0;
         default:                res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Dimension-ordered (X first, then Y) route computation.
module xy_route_calc
   import router_pkg::*;
#(
   parameter int unsigned N_ADD = 2
) (
   input  logic [N_ADD-1:0] x_cur,
   input  logic [N_ADD-1:0] y_cur,
   input  logic [N_ADD-1:0] x_des,
   input  logic [N_ADD-1:0] y_des,
   output logic [2:0]       port
);

   // Resolve X offset first; Y is only considered once X matches.
   always_comb begin
      port = PORT_LOCAL;
      if (x_des > x_cur) begin
         port = PORT_E;
      end else if (x_des < x_cur) begin
         port = PORT_W;
      end else if (y_des > y_cur) begin
         port = PORT_N;
      end else if (y_des < y_cur) begin
         port = PORT_S;
      end
   end

endmodule

// File: rtl/input_route_ctrl.sv
// Wormhole router input controller: pops flits from the input FIFO, routes
// head flits with XY routing, locks the route until the tail, and reports
// protocol errors through a pulse and a saturating counter.
module input_route_ctrl
   import router_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned N_ADD      = 2,
   parameter int unsigned N_REGISTER = 3,
   parameter int unsigned ERR_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_ADD-1:0]      X_cur,
   input  logic [N_ADD-1:0]      Y_cur,
   input  logic [DATA_WIDTH-1:0] Data_in,
   input  logic                  empty,
   output logic                  read,
   input  logic                  grant,
   output logic [DATA_WIDTH-1:0] Data_out,
   output logic                  out_valid,
   output logic [N_REGISTER-1:0] register,
   output logic                  pkt_open,
   output logic                  err_pulse,
   output logic [ERR_W-1:0]      err_cnt
);

   localparam logic [N_REGISTER-1:0] RegNone = N_REGISTER'(PORT_NONE);

   logic [N_ADD-1:0]      x_add_cur;
   logic [N_ADD-1:0]      y_add_cur;
   route_state_e          state_q, state_d;
   logic [N_REGISTER-1:0] lock_q, lock_d;

   logic [1:0]            ftype;
   logic [N_ADD-1:0]      x_des;
   logic [N_ADD-1:0]      y_des;
   logic [2:0]            fresh_route;
   logic                  accept;
   logic                  forward;
   logic                  err_detect;
   logic [N_REGISTER-1:0] flit_route;
   logic [DATA_WIDTH-1:0] data_d;
   logic                  valid_d;
   logic [N_REGISTER-1:0] reg_d;
   logic [ERR_W-1:0]      cnt_d;

   assign ftype = Data_in[DATA_WIDTH-1:DATA_WIDTH-2];
   assign x_des = Data_in[N_ADD-1:0];
   assign y_des = Data_in[2*N_ADD-1:N_ADD];

   xy_route_calc #(
      .N_ADD (N_ADD)
   ) u_xy_route_calc (
      .x_cur (x_add_cur),
      .y_cur (y_add_cur),
      .x_des (x_des),
      .y_des (y_des),
      .port  (fresh_route)
   );

   // Pop path is purely combinational so the FIFO sees back-pressure at once.
   assign read     = accept;
   assign pkt_open = (state_q == StPkt);

   // Handshake, packet FSM next state, output register and error counter.
   always_comb begin
      accept     = rst && !empty && (!out_valid || grant);
      state_d    = state_q;
      lock_d     = lock_q;
      forward    = 1'b0;
      err_detect = 1'b0;
      flit_route = lock_q;
      data_d     = Data_out;
      valid_d    = out_valid;
      reg_d      = register;
      cnt_d      = err_cnt;

      if (accept) begin
         case (state_q)
            StIdle: begin
               if (carries_addr(ftype)) begin
                  forward    = 1'b1;
                  flit_route = N_REGISTER'(fresh_route);
                  // Only a true head opens a packet; a single flit is self-contained.
                  if (ftype == FLIT_HEAD) begin
                     state_d = StPkt;
                     lock_d  = N_REGISTER'(fresh_route);
                  end
               end else begin
                  // Body/tail without a head: popped and dropped.
                  err_detect = 1'b1;
               end
            end
            StPkt: begin
               forward = 1'b1;
               if (ftype == FLIT_TAIL) begin
                  state_d = StIdle;
                  lock_d  = RegNone;
               end else if (carries_addr(ftype)) begin
                  // Misplaced head travels as body on the locked route.
                  err_detect = 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end

      if (forward) begin
         data_d  = Data_in;
         valid_d = 1'b1;
         reg_d   = flit_route;
      end else if (out_valid && grant) begin
         // Granted flit leaves and nothing replaces it.
         data_d  = '0;
         valid_d = 1'b0;
         reg_d   = RegNone;
      end

      if (err_detect && (err_cnt != '1)) begin
         cnt_d = err_cnt + ERR_W'(1);
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         Data_out  <= '0;
         out_valid <= 1'b0;
         register  <= RegNone;
         state_q   <= StIdle;
         lock_q    <= RegNone;
         err_pulse <= 1'b0;
         err_cnt   <= '0;
         x_add_cur <= X_cur;
         y_add_cur <= Y_cur;
      end else begin
         Data_out  <= data_d;
         out_valid <= valid_d;
         register  <= reg_d;
         state_q   <= state_d;
         lock_q    <= lock_d;
         err_pulse <= err_detect;
         err_cnt   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_input_route_ctrl.sv
// Bench for input_route_ctrl: directed vector table, a saturation sequence,
// and randomized traffic against a packet-level reference model.
module tb_input_route_ctrl;

   logic        clk;
   logic        rst;
   logic [1:0]  X_cur;
   logic [1:0]  Y_cur;
   logic [15:0] Data_in;
   logic        empty;
   logic        read;
   logic        grant;
   logic [15:0] Data_out;
   logic        out_valid;
   logic [2:0]  register;
   logic        pkt_open;
   logic        err_pulse;
   logic [7:0]  err_cnt;

   int checks = 0;
   int errors = 0;

   input_route_ctrl #(
      .DATA_WIDTH (16),
      .N_ADD      (2),
      .N_REGISTER (3),
      .ERR_W      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .X_cur     (X_cur),
      .Y_cur     (Y_cur),
      .Data_in   (Data_in),
      .empty     (empty),
      .read      (read),
      .grant     (grant),
      .Data_out  (Data_out),
      .out_valid (out_valid),
      .register  (register),
      .pkt_open  (pkt_open),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        empty;
      logic [15:0] din;
      logic        grant;
      logic        exp_read;
      logic        exp_valid;
      logic [15:0] exp_data;
      logic [2:0]  exp_reg;
      logic        exp_open;
      logic        exp_pulse;
      logic [7:0]  exp_cnt;
   } vec_t;

   localparam int NVEC = 19;
   vec_t tbl [NVEC];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic e, input logic [15:0] d, input logic g,
                               input logic xr, input logic xv, input logic [15:0] xd,
                               input logic [2:0] xg, input logic xo, input logic xp,
                               input logic [7:0] xc);
      vec_t v;
      v.rst = r; v.empty = e; v.din = d; v.grant = g;
      v.exp_read = xr; v.exp_valid = xv; v.exp_data = xd; v.exp_reg = xg;
      v.exp_open = xo; v.exp_pulse = xp; v.exp_cnt = xc;
      return v;
   endfunction

   // Expected XY route from signed coordinate offsets.
   function automatic logic [2:0] ref_route(input int xc, input int yc, input int xd, input int yd);
      int dx;
      int dy;
      dx = xd - xc;
      dy = yd - yc;
      if (dx > 0) return 3'b001;
      if (dx < 0) return 3'b010;
      if (dy > 0) return 3'b011;
      if (dy < 0) return 3'b100;
      return 3'b000;
   endfunction

   // Packet-level reference state.
   logic        m_valid;
   logic [15:0] m_data;
   logic [2:0]  m_reg;
   logic        m_open;
   logic [2:0]  m_lock;
   logic        m_pulse;
   int          m_cnt;
   int          m_x;
   int          m_y;

   task automatic model_edge(input logic popped);
      logic [1:0] t;
      logic [2:0] r;
      if (!rst) begin
         m_valid = 0; m_data = 0; m_reg = 3'b111; m_open = 0; m_lock = 3'b111;
         m_pulse = 0; m_cnt = 0; m_x = int'(X_cur); m_y = int'(Y_cur);
      end else begin
         m_pulse = 0;
         t = Data_in[15:14];
         if (popped) begin
            if (!m_open) begin
               if (t == 2'b01 || t == 2'b11) begin
                  r = ref_route(m_x, m_y, int'(Data_in[1:0]), int'(Data_in[3:2]));
                  m_valid = 1; m_data = Data_in; m_reg = r;
                  if (t == 2'b01) begin
                     m_open = 1; m_lock = r;
                  end
               end else begin
                  m_pulse = 1; m_valid = 0; m_data = 0; m_reg = 3'b111;
               end
            end else begin
               m_valid = 1; m_data = Data_in; m_reg = m_lock;
               if (t == 2'b10) begin
                  m_open = 0; m_lock = 3'b111;
               end else if (t != 2'b00) begin
                  m_pulse = 1;
               end
            end
         end else if (m_valid && grant) begin
            m_valid = 0; m_data = 0; m_reg = 3'b111;
         end
         if (m_pulse && m_cnt < 255) m_cnt++;
      end
   endtask

   initial begin
      logic exp_read;

      rst = 0; empty = 1; Data_in = '0; grant = 1; X_cur = 2'd1; Y_cur = 2'd1;

      //            rst e  din        g  rd vl data       reg     op pl cnt
      tbl[0]  = mk(0, 0, 16'hC005, 1, 0, 0, 16'h0000, 3'b111, 0, 0, 8'd0);
      tbl[1]  = mk(0, 0, 16'hC005, 1, 0, 0, 16'h0000, 3'b111, 0, 0, 8'd0);
      tbl[2]  = mk(1, 0, 16'hC005, 1, 1, 1, 16'hC005, 3'b000, 0, 0, 8'd0);
      tbl[3]  = mk(1, 0, 16'h4006, 1, 1, 1, 16'h4006, 3'b001, 1, 0, 8'd0);
      tbl[4]  = mk(1, 0, 16'h0123, 1, 1, 1, 16'h0123, 3'b001, 1, 0, 8'd0);
      tbl[5]  = mk(1, 0, 16'h8456, 1, 1, 1, 16'h8456, 3'b001, 0, 0, 8'd0);
      tbl[6]  = mk(1, 1, 16'h0000, 1, 0, 0, 16'h0000, 3'b111, 0, 0, 8'd0);
      tbl[7]  = mk(1, 0, 16'h4006, 1, 1, 1, 16'h4006, 3'b001, 1, 0, 8'd0);
      tbl[8]  = mk(1, 0, 16'h0123, 0, 0, 1, 16'h4006, 3'b001, 1, 0, 8'd0);
      tbl[9]  = mk(1, 0, 16'h0123, 0, 0, 1, 16'h4006, 3'b001, 1, 0, 8'd0);
      tbl[10] = mk(1, 0, 16'h0123, 0, 0, 1, 16'h4006, 3'b001, 1, 0, 8'd0);
      tbl[11] = mk(1, 0, 16'h0123, 1, 1, 1, 16'h0123, 3'b001, 1, 0, 8'd0);
      tbl[12] = mk(1, 0, 16'h8456, 1, 1, 1, 16'h8456, 3'b001, 0, 0, 8'd0);
      tbl[13] = mk(1, 1, 16'h0000, 1, 0, 0, 16'h0000, 3'b111, 0, 0, 8'd0);
      tbl[14] = mk(1, 0, 16'h8000, 1, 1, 0, 16'h0000, 3'b111, 0, 1, 8'd1);
      tbl[15] = mk(1, 1, 16'h0000, 1, 0, 0, 16'h0000, 3'b111, 0, 0, 8'd1);
      tbl[16] = mk(1, 0, 16'h4009, 1, 1, 1, 16'h4009, 3'b011, 1, 0, 8'd1);
      tbl[17] = mk(1, 0, 16'hC005, 1, 1, 1, 16'hC005, 3'b011, 1, 1, 8'd2);
      tbl[18] = mk(1, 0, 16'h8000, 1, 1, 1, 16'h8000, 3'b011, 0, 0, 8'd2);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         rst = tbl[i].rst; empty = tbl[i].empty; Data_in = tbl[i].din; grant = tbl[i].grant;
         #1;
         chk($sformatf("tbl%0d_read", i), read, tbl[i].exp_read);
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_valid);
         chk($sformatf("tbl%0d_data", i), Data_out, tbl[i].exp_data);
         chk($sformatf("tbl%0d_reg", i), register, tbl[i].exp_reg);
         chk($sformatf("tbl%0d_open", i), pkt_open, tbl[i].exp_open);
         chk($sformatf("tbl%0d_pulse", i), err_pulse, tbl[i].exp_pulse);
         chk($sformatf("tbl%0d_cnt", i), err_cnt, tbl[i].exp_cnt);
      end

      // Stray body flits in IDLE drive the error counter into saturation.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         rst = 1; empty = 0; Data_in = 16'h0000; grant = 1;
         #1;
         chk("sat_read", read, 1);
         @(posedge clk);
         #1;
         chk("sat_valid", out_valid, 0);
         chk("sat_pulse", err_pulse, 1);
         chk("sat_cnt", err_cnt, (3 + i > 255) ? 255 : 3 + i);
      end
      @(negedge clk);
      empty = 1;
      @(posedge clk);
      #1;
      chk("sat_final_cnt", err_cnt, 255);
      chk("sat_final_pulse", err_pulse, 0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst     = (i < 2) ? 1'b0 : (($urandom_range(0, 199) < 3) ? 1'b0 : 1'b1);
         empty   = ($urandom_range(0, 9) < 3);
         Data_in = 16'($urandom);
         grant   = ($urandom_range(0, 9) < 7);
         X_cur   = 2'($urandom);
         Y_cur   = 2'($urandom);
         #1;
         exp_read = rst && !empty && (!m_valid || grant);
         if (i >= 2) chk("rnd_read", read, exp_read);
         @(posedge clk);
         model_edge(exp_read);
         #1;
         chk("rnd_valid", out_valid, m_valid);
         chk("rnd_data", Data_out, m_data);
         chk("rnd_reg", register, m_reg);
         chk("rnd_open", pkt_open, m_open);
         chk("rnd_pulse", err_pulse, m_pulse);
         chk("rnd_cnt", err_cnt, m_cnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
